// File: rtl/lockstep_sched.sv
// rtl/lockstep_sched.sv - dual-core lockstep retirement scheduler with compare and watchdog
module lockstep_sched #(
  parameter int OBS_W   = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             retire_1_i,
  input  logic             retire_2_i,
  input  logic [OBS_W-1:0] obs_1_i,
  input  logic [OBS_W-1:0] obs_2_i,
  input  logic             halt_1_i,
  input  logic             halt_2_i,
  output logic             en_1_o,
  output logic             en_2_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             mismatch_o,
  output logic             timeout_o,
  output logic             done_o
);

  // Wait counter only has to reach TIMEOUT-1 before the watchdog fires.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT_1,
    ST_WAIT_2,
    ST_HWAIT_1,
    ST_HWAIT_2,
    ST_DONE,
    ST_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OBS_W-1:0]   cap_q, cap_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               retire_q, retire_d;
  logic               mism_q, mism_d;
  logic               tmo_q, tmo_d;

  logic               en_1, en_2;
  logic               r1, r2, h1, h2;
  logic [CNT_W-1:0]   cnt_inc;
  logic               cnt_full;
  logic               timed_out;

  // Per-core enables follow the state; strobes from a stalled core are masked,
  // and a halt hides a same-cycle retire from that core.
  always_comb begin
    en_1      = (state_q == ST_RUN) || (state_q == ST_WAIT_1) || (state_q == ST_HWAIT_1);
    en_2      = (state_q == ST_RUN) || (state_q == ST_WAIT_2) || (state_q == ST_HWAIT_2);
    h1        = halt_1_i & en_1;
    h2        = halt_2_i & en_2;
    r1        = retire_1_i & en_1 & ~h1;
    r2        = retire_2_i & en_2 & ~h2;
    cnt_inc   = cnt_q + 1'b1;
    cnt_full  = &cnt_inc;
    timed_out = (wait_q == WAIT_W'(TIMEOUT - 1));
  end

  // Next-state logic: pairing, comparison, halt handling and watchdog.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    wait_d   = wait_q + 1'b1;
    retire_d = 1'b0;
    mism_d   = mism_q;
    tmo_d    = tmo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (h1 && h2) begin
          state_d = ST_DONE;
        end else if (h1) begin
          // Core 2 retiring while core 1 ends its program is divergence.
          if (r2) begin
            mism_d  = 1'b1;
            state_d = ST_FAIL;
          end else begin
            wait_d  = '0;
            state_d = ST_HWAIT_2;
          end
        end else if (h2) begin
          if (r1) begin
            mism_d  = 1'b1;
            state_d = ST_FAIL;
          end else begin
            wait_d  = '0;
            state_d = ST_HWAIT_1;
          end
        end else if (r1 && r2) begin
          if (obs_1_i == obs_2_i) begin
            retire_d = 1'b1;
            cnt_d    = cnt_inc;
            if (cnt_full) state_d = ST_DONE;
          end else begin
            mism_d  = 1'b1;
            state_d = ST_FAIL;
          end
        end else if (r1) begin
          cap_d   = obs_1_i;
          wait_d  = '0;
          state_d = ST_WAIT_2;
        end else if (r2) begin
          cap_d   = obs_2_i;
          wait_d  = '0;
          state_d = ST_WAIT_1;
        end
      end

      ST_WAIT_1: begin
        if (h1) begin
          mism_d  = 1'b1;
          state_d = ST_FAIL;
        end else if (r1) begin
          if (obs_1_i == cap_q) begin
            retire_d = 1'b1;
            cnt_d    = cnt_inc;
            state_d  = cnt_full ? ST_DONE : ST_RUN;
          end else begin
            mism_d  = 1'b1;
            state_d = ST_FAIL;
          end
        end else if (timed_out) begin
          tmo_d   = 1'b1;
          state_d = ST_FAIL;
        end
      end

      ST_WAIT_2: begin
        if (h2) begin
          mism_d  = 1'b1;
          state_d = ST_FAIL;
        end else if (r2) begin
          if (obs_2_i == cap_q) begin
            retire_d = 1'b1;
            cnt_d    = cnt_inc;
            state_d  = cnt_full ? ST_DONE : ST_RUN;
          end else begin
            mism_d  = 1'b1;
            state_d = ST_FAIL;
          end
        end else if (timed_out) begin
          tmo_d   = 1'b1;
          state_d = ST_FAIL;
        end
      end

      ST_HWAIT_1: begin
        if (h1) begin
          state_d = ST_DONE;
        end else if (r1) begin
          mism_d  = 1'b1;
          state_d = ST_FAIL;
        end else if (timed_out) begin
          tmo_d   = 1'b1;
          state_d = ST_FAIL;
        end
      end

      ST_HWAIT_2: begin
        if (h2) begin
          state_d = ST_DONE;
        end else if (r2) begin
          mism_d  = 1'b1;
          state_d = ST_FAIL;
        end else if (timed_out) begin
          tmo_d   = 1'b1;
          state_d = ST_FAIL;
        end
      end

      ST_DONE, ST_FAIL: begin
        if (start_i) begin
          cnt_d   = '0;
          cap_d   = '0;
          mism_d  = 1'b0;
          tmo_d   = 1'b0;
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and status registers; async reset clears everything at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cap_q    <= '0;
      wait_q   <= '0;
      retire_q <= 1'b0;
      mism_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      wait_q   <= wait_d;
      retire_q <= retire_d;
      mism_q   <= mism_d;
      tmo_q    <= tmo_d;
    end
  end

  assign en_1_o       = en_1;
  assign en_2_o       = en_2;
  assign retire_o     = retire_q;
  assign retire_cnt_o = cnt_q;
  assign mismatch_o   = mism_q;
  assign timeout_o    = tmo_q;
  assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_lockstep_sched.sv
// tb/tb_lockstep_sched.sv - directed self-checking bench for lockstep_sched
module tb_lockstep_sched;
  localparam int OBS_W   = 8;
  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 4;

  logic             clk_i = 1'b0;
  logic             rst_i, start_i;
  logic             retire_1_i, retire_2_i, halt_1_i, halt_2_i;
  logic [OBS_W-1:0] obs_1_i, obs_2_i;
  logic             en_1_o, en_2_o, retire_o, mismatch_o, timeout_o, done_o;
  logic [CNT_W-1:0] retire_cnt_o;

  int checks = 0;
  int errors = 0;

  lockstep_sched #(.OBS_W(OBS_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .retire_1_i(retire_1_i), .retire_2_i(retire_2_i),
    .obs_1_i(obs_1_i), .obs_2_i(obs_2_i),
    .halt_1_i(halt_1_i), .halt_2_i(halt_2_i),
    .en_1_o(en_1_o), .en_2_o(en_2_o), .retire_o(retire_o),
    .retire_cnt_o(retire_cnt_o), .mismatch_o(mismatch_o),
    .timeout_o(timeout_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog expired got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    start_i = 0; retire_1_i = 0; retire_2_i = 0; halt_1_i = 0; halt_2_i = 0;
    obs_1_i = '0; obs_2_i = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk_i); #1;
    idle();
  endtask

  task automatic do_start();
    start_i = 1; step();
  endtask

  task automatic test_reset();
    idle(); rst_i = 1;
    repeat (2) @(posedge clk_i); #1;
    checks++; if ({en_1_o, en_2_o, retire_o, mismatch_o, timeout_o, done_o} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b required 000000", {en_1_o, en_2_o, retire_o, mismatch_o, timeout_o, done_o}); end
    checks++; if (retire_cnt_o !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d required 0", retire_cnt_o); end
    rst_i = 0; step();
    checks++; if ({en_1_o, en_2_o} !== 2'b00) begin errors++; $display("FAIL idle_en got %b required 00", {en_1_o, en_2_o}); end
  endtask

  task automatic test_pair_same_cycle();
    do_start();
    checks++; if ({en_1_o, en_2_o} !== 2'b11) begin errors++; $display("FAIL run_en got %b required 11", {en_1_o, en_2_o}); end
    retire_1_i = 1; retire_2_i = 1; obs_1_i = 8'hA5; obs_2_i = 8'hA5; step();
    checks++; if (retire_o !== 1'b1) begin errors++; $display("FAIL pair_retire got %b required 1", retire_o); end
    checks++; if (retire_cnt_o !== 3'd1) begin errors++; $display("FAIL pair_cnt got %0d required 1", retire_cnt_o); end
    checks++; if ({en_1_o, en_2_o} !== 2'b11) begin errors++; $display("FAIL pair_en got %b required 11", {en_1_o, en_2_o}); end
    step();
    checks++; if (retire_o !== 1'b0) begin errors++; $display("FAIL pair_pulse_width got %b required 0", retire_o); end
  endtask

  task automatic test_lagging_core();
    retire_1_i = 1; obs_1_i = 8'h10; step();
    for (int i = 0; i < 3; i++) begin
      checks++; if ({en_1_o, en_2_o} !== 2'b01) begin errors++; $display("FAIL lag_en cycle %0d got %b required 01", i, {en_1_o, en_2_o}); end
      checks++; if (retire_o !== 1'b0) begin errors++; $display("FAIL lag_no_retire cycle %0d got %b required 0", i, retire_o); end
      if (i == 0) begin retire_1_i = 1; obs_1_i = 8'h55; end
      if (i == 2) begin retire_2_i = 1; obs_2_i = 8'h10; end
      step();
    end
    checks++; if (retire_o !== 1'b1) begin errors++; $display("FAIL lag_retire got %b required 1", retire_o); end
    checks++; if (retire_cnt_o !== 3'd2) begin errors++; $display("FAIL lag_cnt got %0d required 2", retire_cnt_o); end
    checks++; if ({en_1_o, en_2_o} !== 2'b11) begin errors++; $display("FAIL lag_back_to_run got %b required 11", {en_1_o, en_2_o}); end
  endtask

  task automatic test_mismatch();
    retire_1_i = 1; obs_1_i = 8'h10; step();
    retire_2_i = 1; obs_2_i = 8'h11; step();
    checks++; if (mismatch_o !== 1'b1) begin errors++; $display("FAIL mm_flag got %b required 1", mismatch_o); end
    checks++; if ({en_1_o, en_2_o, retire_o, done_o} !== 4'b0000) begin errors++; $display("FAIL mm_state got %b required 0000", {en_1_o, en_2_o, retire_o, done_o}); end
    checks++; if (retire_cnt_o !== 3'd2) begin errors++; $display("FAIL mm_cnt got %0d required 2", retire_cnt_o); end
    step();
    checks++; if (mismatch_o !== 1'b1) begin errors++; $display("FAIL mm_sticky got %b required 1", mismatch_o); end
    do_start();
    checks++; if ({mismatch_o, retire_cnt_o, en_1_o, en_2_o} !== {1'b0, 3'd0, 2'b11}) begin
      errors++; $display("FAIL mm_restart got %b required 000011", {mismatch_o, retire_cnt_o, en_1_o, en_2_o}); end
  endtask

  task automatic test_timeout();
    retire_1_i = 1; obs_1_i = 8'h33; step();
    repeat (TIMEOUT - 1) step();
    checks++; if ({timeout_o, en_2_o} !== 2'b01) begin errors++; $display("FAIL tmo_early got %b required 01", {timeout_o, en_2_o}); end
    step();
    checks++; if ({timeout_o, mismatch_o, en_1_o, en_2_o} !== 4'b1000) begin
      errors++; $display("FAIL tmo_fire got %b required 1000", {timeout_o, mismatch_o, en_1_o, en_2_o}); end
  endtask

  task automatic test_halts();
    do_start();
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL tmo_restart got %b required 0", timeout_o); end
    halt_1_i = 1; step();
    checks++; if ({en_1_o, en_2_o} !== 2'b01) begin errors++; $display("FAIL hwait_en got %b required 01", {en_1_o, en_2_o}); end
    retire_2_i = 1; obs_2_i = 8'h01; step();
    checks++; if ({mismatch_o, done_o, retire_o} !== 3'b100) begin errors++; $display("FAIL halt_diverge got %b required 100", {mismatch_o, done_o, retire_o}); end
    do_start();
    halt_1_i = 1; step();
    halt_2_i = 1; step();
    checks++; if ({done_o, mismatch_o, en_1_o, en_2_o} !== 4'b1000) begin
      errors++; $display("FAIL halt_done got %b required 1000", {done_o, mismatch_o, en_1_o, en_2_o}); end
    do_start();
    retire_1_i = 1; halt_1_i = 1; retire_2_i = 1; halt_2_i = 1; obs_1_i = 8'h01; obs_2_i = 8'h02; step();
    checks++; if ({done_o, mismatch_o, retire_o, retire_cnt_o} !== {3'b100, 3'd0}) begin
      errors++; $display("FAIL halt_priority got %b required 100000", {done_o, mismatch_o, retire_o, retire_cnt_o}); end
  endtask

  task automatic test_back_to_back_saturate();
    do_start();
    for (int i = 1; i <= 7; i++) begin
      retire_1_i = 1; retire_2_i = 1; obs_1_i = 8'(i * 3); obs_2_i = 8'(i * 3); step();
      checks++; if ({retire_o, retire_cnt_o} !== {1'b1, 3'(i)}) begin
        errors++; $display("FAIL b2b_%0d got %b required %b", i, {retire_o, retire_cnt_o}, {1'b1, 3'(i)}); end
    end
    checks++; if ({done_o, en_1_o, en_2_o} !== 3'b100) begin errors++; $display("FAIL sat_done got %b required 100", {done_o, en_1_o, en_2_o}); end
    retire_1_i = 1; retire_2_i = 1; step();
    checks++; if ({retire_o, retire_cnt_o} !== {1'b0, 3'd7}) begin
      errors++; $display("FAIL sat_nowrap got %b required 0111", {retire_o, retire_cnt_o}); end
  endtask

  task automatic test_async_reset();
    do_start();
    retire_1_i = 1; retire_2_i = 1; obs_1_i = 8'h7E; obs_2_i = 8'h7E; step();
    retire_1_i = 1; obs_1_i = 8'h44; step();
    checks++; if ({en_1_o, en_2_o, retire_cnt_o} !== {2'b01, 3'd1}) begin
      errors++; $display("FAIL ar_pre got %b required 01001", {en_1_o, en_2_o, retire_cnt_o}); end
    #2 rst_i = 1;
    #1;
    checks++; if ({en_1_o, en_2_o, retire_o, mismatch_o, timeout_o, done_o, retire_cnt_o} !== 9'b0) begin
      errors++; $display("FAIL ar_async got %b required 000000000", {en_1_o, en_2_o, retire_o, mismatch_o, timeout_o, done_o, retire_cnt_o}); end
    step();
    rst_i = 0; step();
    do_start();
    retire_1_i = 1; retire_2_i = 1; obs_1_i = 8'h09; obs_2_i = 8'h09; step();
    checks++; if ({retire_o, retire_cnt_o} !== {1'b1, 3'd1}) begin
      errors++; $display("FAIL ar_resume got %b required 1001", {retire_o, retire_cnt_o}); end
  endtask

  initial begin
    test_reset();
    test_pair_same_cycle();
    test_lagging_core();
    test_mismatch();
    test_timeout();
    test_halts();
    test_back_to_back_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
